// File: rtl/serial_word_rx.sv
// serial_word_rx
//   Serial-to-parallel word receiver. Consumes one bit per sys_clk from the
//   upstream delay line, frames words as
//     start(1) | DATA_W data bits, LSB first | [even parity] | stop(0)
//   and presents each good word on a valid/ready output register.
//
//   Build option: define PARITY_CHK_EN to include the even-parity bit and
//   its check. Without it the parity bit is absent from the frame and
//   parity_err is constant 0.
//
// Parameters
//   DATA_W      data bits per frame (2..32)
// Ports
//   sys_clk     clock
//   sys_rst_n   asynchronous active-low reset
//   din         serial bit stream, idle level 0
//   dout_ready  consumer accepts dout when high while dout_valid is high
//   dout        received word, bit 0 = first data bit received
//   dout_valid  dout holds an unaccepted word
//   frame_err   one-cycle pulse: stop bit was 1, word dropped
//   parity_err  one-cycle pulse: parity mismatch, word dropped
//   overrun     one-cycle pulse: good word dropped, output register full
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a start bit (din = 1)
// DATA   | sampling data bit bit_cnt into the shift register
// PARITY | sampling the even-parity bit (PARITY_CHK_EN builds only)
// STOP   | sampling the stop bit; deliver or drop the word

module serial_word_rx #(
  parameter int DATA_W = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              din,
  input  logic              dout_ready,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

`ifdef PARITY_CHK_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_STOP   = 2'd3
  } state_t;
`endif

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              par_flag;

  logic cnt_clr;
  logic shift_en;
  logic deliver;
  logic frame_bad;
  logic parity_bad;
  logic accept;

`ifdef PARITY_CHK_EN
  logic par_load;
`endif

  // ---------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // FSM next state and control strobes
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    cnt_clr    = 1'b0;
    shift_en   = 1'b0;
    deliver    = 1'b0;
    frame_bad  = 1'b0;
    parity_bad = 1'b0;
`ifdef PARITY_CHK_EN
    par_load   = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (din) begin
          state_nxt = S_DATA;
          cnt_clr   = 1'b1;
        end
      end
      S_DATA: begin
        shift_en = 1'b1;
        if (bit_cnt == LAST_BIT) begin
`ifdef PARITY_CHK_EN
          state_nxt = S_PARITY;
`else
          state_nxt = S_STOP;
`endif
        end
      end
`ifdef PARITY_CHK_EN
      S_PARITY: begin
        par_load  = 1'b1;
        state_nxt = S_STOP;
      end
`endif
      S_STOP: begin
        // A 1 here is the (bad) stop bit, never a new start bit.
        state_nxt = S_IDLE;
        if (din) begin
          frame_bad = 1'b1;
        end else if (par_flag) begin
          parity_bad = 1'b1;
        end else begin
          deliver = 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Bit counter and shift register
  // ---------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (cnt_clr) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (shift_en) begin
      shreg[bit_cnt] <= din;
      bit_cnt        <= bit_cnt + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Parity mismatch flag: set when data bits XOR parity bit is odd.
  // ---------------------------------------------------------------------
`ifdef PARITY_CHK_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      par_flag <= 1'b0;
    end else if (par_load) begin
      par_flag <= din ^ (^shreg);
    end
  end
`else
  assign par_flag = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Output register and status pulses
  // ---------------------------------------------------------------------
  assign accept = dout_valid & dout_ready;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= frame_bad;
      parity_err <= parity_bad;
      overrun    <= 1'b0;
      if (deliver && (!dout_valid || accept)) begin
        dout       <= shreg;
        dout_valid <= 1'b1;
      end else if (deliver) begin
        // Held word is kept; the newer one is lost.
        overrun <= 1'b1;
      end else if (accept) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_word_rx.sv
module tb_serial_word_rx;

  localparam int DATA_W = 8;

  logic              sys_clk    = 1'b0;
  logic              sys_rst_n  = 1'b1;
  logic              din        = 1'b0;
  logic              dout_ready = 1'b0;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              frame_err;
  logic              parity_err;
  logic              overrun;

  int n_checks = 0;
  int n_errors = 0;

  logic [DATA_W-1:0] exp_q[$];

  int n_frame_err  = 0;
  int n_parity_err = 0;
  int n_overrun    = 0;
  int n_valid_cyc  = 0;

  logic              prev_valid  = 1'b0;
  logic              prev_accept = 1'b0;
  logic [DATA_W-1:0] prev_dout   = '0;

`ifdef PARITY_CHK_EN
  logic par_corrupt = 1'b0;
`endif

  serial_word_rx #(.DATA_W(DATA_W)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .din        (din),
    .dout_ready (dout_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; outputs are sampled
  // on the falling edge, where they match what the next rising edge sees.
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (prev_valid && !prev_accept && dout_valid)
        check("dout_stable", 32'(dout), 32'(prev_dout));
      if (dout_valid)  n_valid_cyc++;
      if (frame_err)   n_frame_err++;
      if (parity_err)  n_parity_err++;
      if (overrun)     n_overrun++;
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0)
          check("sb_word_expected", 32'(exp_q.size()), 32'd1);
        else
          check("sb_word", 32'(dout), 32'(exp_q.pop_front()));
      end
    end
    prev_valid  = dout_valid;
    prev_accept = dout_valid && dout_ready;
    prev_dout   = dout;
  end

  task automatic drive_bit(input logic b);
    din = b;
    @(posedge sys_clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) drive_bit(1'b0);
  endtask

  // Returns 2 time units after the edge that samples the stop bit.
  task automatic send_frame(input logic [DATA_W-1:0] d, input logic stop, input logic ready_stop);
    logic saved;
    drive_bit(1'b1);
    for (int i = 0; i < DATA_W; i++) drive_bit(d[i]);
`ifdef PARITY_CHK_EN
    drive_bit((^d) ^ par_corrupt);
`endif
    saved      = dout_ready;
    dout_ready = ready_stop;
    din        = stop;
    @(posedge sys_clk);
    #2;
    dout_ready = saved;
    din        = 1'b0;
  endtask

  initial begin
    int v0, f0, p0, o0;

    #1 sys_rst_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    #2;
    check("reset_outputs", 32'({dout, dout_valid, frame_err, parity_err, overrun}), 32'd0);
    sys_rst_n = 1'b1;
    idle(2);

    // Single frame, consumer always ready.
    dout_ready = 1'b1;
    v0 = n_valid_cyc;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b0, 1'b1);
    check("t1_valid_after_stop", 32'(dout_valid), 32'd1);
    check("t1_dout_after_stop", 32'(dout), 32'hA5);
    idle(3);
    check("t1_valid_cycles", 32'(n_valid_cyc - v0), 32'd1);

    // Back to back with consumer stalled: second word overruns.
    dout_ready = 1'b0;
    o0 = n_overrun;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b0, 1'b0);
    send_frame(8'hC3, 1'b0, 1'b0);
    check("t2_overrun_now", 32'(overrun), 32'd1);
    idle(2);
    check("t2_overrun_count", 32'(n_overrun - o0), 32'd1);
    check("t2_dout_held", 32'(dout), 32'h3C);
    check("t2_valid_held", 32'(dout_valid), 32'd1);
    dout_ready = 1'b1;
    idle(1);
    dout_ready = 1'b0;
    idle(1);
    check("t2_drained", 32'(dout_valid), 32'd0);

    // Accept coincides with second stop bit: replace, no overrun.
    o0 = n_overrun;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    send_frame(8'h3C, 1'b0, 1'b0);
    send_frame(8'hC3, 1'b0, 1'b1);
    check("t3_dout_new", 32'(dout), 32'hC3);
    check("t3_valid_kept", 32'(dout_valid), 32'd1);
    idle(2);
    check("t3_no_overrun", 32'(n_overrun - o0), 32'd0);
    dout_ready = 1'b1;
    idle(1);
    dout_ready = 1'b0;
    idle(1);

    // Framing error, then a frame starting on the very next cycle.
    dout_ready = 1'b1;
    f0 = n_frame_err;
    v0 = n_valid_cyc;
    send_frame(8'h55, 1'b1, 1'b1);
    check("t4_frame_err_now", 32'(frame_err), 32'd1);
    check("t4_no_valid", 32'(dout_valid), 32'd0);
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b0, 1'b1);
    idle(3);
    check("t4_frame_err_count", 32'(n_frame_err - f0), 32'd1);
    check("t4_valid_cycles", 32'(n_valid_cyc - v0), 32'd1);

`ifdef PARITY_CHK_EN
    p0 = n_parity_err;
    v0 = n_valid_cyc;
    par_corrupt = 1'b0;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b0, 1'b1);
    par_corrupt = 1'b1;
    send_frame(8'h07, 1'b0, 1'b1);
    check("t5_parity_err_now", 32'(parity_err), 32'd1);
    par_corrupt = 1'b0;
    idle(3);
    check("t5_parity_err_count", 32'(n_parity_err - p0), 32'd1);
    check("t5_valid_cycles", 32'(n_valid_cyc - v0), 32'd1);
`else
    p0 = n_parity_err;
`endif

    // Reset mid-frame while a word is held.
    dout_ready = 1'b0;
    send_frame(8'h99, 1'b0, 1'b0);
    check("t6_held_before_reset", 32'(dout_valid), 32'd1);
    drive_bit(1'b1);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    sys_rst_n = 1'b0;
    #1;
    check("t6_outputs_in_reset", 32'({dout, dout_valid, frame_err, parity_err, overrun}), 32'd0);
    @(posedge sys_clk);
    #2;
    din       = 1'b0;
    sys_rst_n = 1'b1;
    idle(1);
    dout_ready = 1'b1;
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b0, 1'b1);
    check("t6_dout_after_reset", 32'(dout), 32'h81);
    idle(3);

`ifndef PARITY_CHK_EN
    check("parity_err_never", 32'(n_parity_err - p0), 32'd0);
`endif
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
